// File: rtl/ctrl_pipe.sv
// Control-word pipeline behind decode: per-stage stall/flush with bubble insertion.
// Define CTRL_PIPE_PERF_EN to build the retire/bubble performance counters.
module ctrl_pipe #(
    parameter int unsigned CW     = 16,
    parameter int unsigned STAGES = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CW-1:0]        ctrlD,
    input  logic                 validD,
    input  logic [STAGES-1:0]    stall,
    input  logic [STAGES-1:0]    flush,
    output logic [STAGES*CW-1:0] ctrl_q,
    output logic [STAGES-1:0]    valid_q,
    output logic                 stallD,
    output logic [31:0]          retire_cnt,
    output logic [31:0]          bubble_cnt
);

    logic [CW-1:0]     r_ctrl [STAGES];
    logic [STAGES-1:0] r_valid;

    logic [STAGES-1:0] w_se;
    logic [CW-1:0]     w_ctrl_d [STAGES];
    logic [STAGES-1:0] w_valid_d;
    logic              w_acc;

    // Stall seen by a stage is its own request OR-ed with every stage downstream of it.
    always_comb begin
        w_se  = '0;
        w_acc = 1'b0;
        for (int i = 0; i < int'(STAGES); i++) begin
            w_acc                = w_acc | stall[STAGES-1-i];
            w_se[STAGES-1-i]     = w_acc;
        end
    end

    assign stallD = w_se[0];

    always_comb begin
        for (int k = 0; k < int'(STAGES); k++) begin
            w_ctrl_d[k] = r_ctrl[k];
        end
        w_valid_d = r_valid;

        if (flush[0]) begin
            w_ctrl_d[0]  = '0;
            w_valid_d[0] = 1'b0;
        end else if (!w_se[0]) begin
            w_ctrl_d[0]  = ctrlD;
            w_valid_d[0] = validD;
        end

        for (int k = 1; k < int'(STAGES); k++) begin
            if (flush[k]) begin
                w_ctrl_d[k]  = '0;
                w_valid_d[k] = 1'b0;
            end else if (w_se[k]) begin
                w_ctrl_d[k]  = r_ctrl[k];
                w_valid_d[k] = r_valid[k];
            end else if (w_se[k-1]) begin
                w_ctrl_d[k]  = '0;
                w_valid_d[k] = 1'b0;
            end else begin
                w_ctrl_d[k]  = r_ctrl[k-1];
                w_valid_d[k] = r_valid[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                r_ctrl[k] <= '0;
            end
            r_valid <= '0;
        end else begin
            for (int k = 0; k < int'(STAGES); k++) begin
                r_ctrl[k] <= w_ctrl_d[k];
            end
            r_valid <= w_valid_d;
        end
    end

    always_comb begin
        ctrl_q = '0;
        for (int k = 0; k < int'(STAGES); k++) begin
            ctrl_q[k*CW +: CW] = r_ctrl[k];
        end
    end

    assign valid_q = r_valid;

`ifdef CTRL_PIPE_PERF_EN
    logic [31:0] r_retire_cnt;
    logic [31:0] r_bubble_cnt;
    logic        w_retire_inc;
    logic        w_bubble_inc;

    // A held last stage retires only on the edge it finally leaves.
    assign w_retire_inc = r_valid[STAGES-1] & ~w_se[STAGES-1];
    assign w_bubble_inc = flush[0] | (~w_se[0] & ~validD);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_retire_cnt <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_retire_inc) r_retire_cnt <= r_retire_cnt + 32'd1;
            if (w_bubble_inc) r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end

    assign retire_cnt = r_retire_cnt;
    assign bubble_cnt = r_bubble_cnt;
`else
    assign retire_cnt = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: doc/ctrl_pipe.md
CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 Parameter CW, default 16: width in bits of one decoded control word.
REQ-002 Parameter STAGES, default 3: number of pipeline stages after decode (E, M, W at default); legal range 2..8.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 ctrlD  input  CW  decoded control word from the decode stage.
REQ-006 validD  input  1  ctrlD carries a real instruction.
REQ-007 stall  input  STAGES  per-stage hold request; bit 0 is the first stage after decode (E).
REQ-008 flush  input  STAGES  per-stage bubble request; bit 0 is E.
REQ-009 ctrl_q  output  STAGES*CW  control word held in each stage; stage k occupies bits [k*CW+CW-1 : k*CW].
REQ-010 valid_q  output  STAGES  per-stage valid bit.
REQ-011 stallD  output  1  decode must hold its instruction this cycle.
REQ-012 retire_cnt  output  32  count of valid words that have left the last stage.
REQ-013 bubble_cnt  output  32  count of bubbles that have entered stage 0.

Function
REQ-014 Effective stall: se[STAGES-1] = stall[STAGES-1]; se[k] = stall[k] | se[k+1] for k < STAGES-1; the block SHALL compute this combinationally each cycle.
REQ-015 stallD SHALL equal se[0], combinationally.
REQ-016 Stage k update on each rising edge, evaluated in priority order:
- flush[k]=1: ctrl=0, valid=0.
- else se[k]=1: hold the current contents.
- else k=0: load ctrlD/validD.
- else k>0 with se[k-1]=1: ctrl=0, valid=0 (bubble inserted behind a stalled stage).
- else k>0: load the contents of stage k-1.
REQ-017 Flush SHALL win over stall in the same stage; a flushed stage that is also stalled SHALL become a bubble and SHALL still propagate stall upstream.
REQ-018 When validD=0, the block SHALL load ctrlD into stage 0 as-is; downstream qualifies it with valid_q.
REQ-019 Latency: an unstalled, unflushed word presented at ctrlD SHALL appear in stage k exactly k+1 cycles later.
REQ-020 ctrl_q and valid_q SHALL be driven directly from registers, with no combinational path from any input.
REQ-021 retire_cnt SHALL increment by 1 on each edge where valid_q[STAGES-1]=1 and se[STAGES-1]=0, so a stalled last stage is counted once.
REQ-022 bubble_cnt SHALL increment by 1 on each edge where stage 0 is written with valid=0 (flush[0], or a load with validD=0).
REQ-023 Both counters SHALL wrap from 0xFFFFFFFF to 0 silently.

Reset
REQ-024 While rst=0, all ctrl_q bits, valid_q, retire_cnt and bubble_cnt SHALL be 0, asynchronously.
REQ-025 Reset asserted mid-stall SHALL discard all in-flight words.
REQ-026 The first edge after rst deasserts SHALL perform a normal update.

Configuration
REQ-027 Macro CTRL_PIPE_PERF_EN: when defined, retire_cnt and bubble_cnt SHALL be implemented as specified in REQ-021 to REQ-023.
REQ-028 When CTRL_PIPE_PERF_EN is undefined, both counter outputs SHALL be constant 0 and no counter flops SHALL exist; all other behaviour is unchanged.

Verification (CW=16, STAGES=3, CTRL_PIPE_PERF_EN defined)
REQ-029 Stream: ctrlD=0x0001,0x0002,0x0003 with validD=1 and no stall/flush -> ctrl_q stage 2 shows 0x0001,0x0002,0x0003 on cycles 3,4,5; retire_cnt reaches 3.
REQ-030 Stall M: stall=3'b010 for 2 cycles with 0x00A1 in M and 0x00A2 in E -> stallD=1; M and E hold; W receives 2 bubbles; retire_cnt grows by 0 during the stall.
REQ-031 Flush plus stall: flush=3'b001 and stall=3'b001 together with 0x00B0 in E -> E becomes 0/valid 0; stallD=1; decode word still pending; bubble_cnt +1.
REQ-032 Mid-run reset: rst low for 1 cycle while all stages are valid -> all outputs 0 immediately; the next ctrlD=0x1234 reaches stage 2 three cycles after release.
REQ-033 Counter wrap: force retire_cnt to 0xFFFFFFFF, then retire one word -> retire_cnt=0.
REQ-034 Build without CTRL_PIPE_PERF_EN and repeat REQ-029 -> identical ctrl_q/valid_q behaviour; retire_cnt=bubble_cnt=0 throughout.
